// File: rtl/avuart_fifo_bridge.sv
// Avalon-MM slave with the JTAG-UART DATA/CONTROL register model, bridging the host
// bus to a host->tx byte FIFO and an rx->host byte FIFO with parametrised depths and IRQ thresholds.
module avuart_fifo_bridge #(
    parameter int WR_DEPTH  = 64,
    parameter int RD_DEPTH  = 64,
    parameter int WR_THRESH = 8,
    parameter int RD_THRESH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        av_chipselect,
    input  logic        av_address,
    input  logic        av_read_n,
    input  logic        av_write_n,
    input  logic [31:0] av_writedata,
    output logic [31:0] av_readdata,
    output logic        av_waitrequest,
    output logic        irq,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int WA = $clog2(WR_DEPTH);
    localparam int WC = WA + 1;
    localparam int RA = $clog2(RD_DEPTH);
    localparam int RC = RA + 1;
    localparam logic [WC-1:0] WR_DEPTH_C  = WC'(WR_DEPTH);
    localparam logic [WC-1:0] WR_THRESH_C = WC'(WR_THRESH);
    localparam logic [RC-1:0] RD_DEPTH_C  = RC'(RD_DEPTH);
    localparam logic [RC-1:0] RD_THRESH_C = RC'(RD_THRESH);

    logic [7:0]    wr_mem_r [WR_DEPTH];
    logic [WA-1:0] wr_wptr_r, wr_rptr_r;
    logic [WC-1:0] wr_count_r, wr_count_nxt_s, wspace_s;
    logic [7:0]    rd_mem_r [RD_DEPTH];
    logic [RA-1:0] rd_wptr_r, rd_rptr_r;
    logic [RC-1:0] rd_count_r, rd_count_nxt_s;

    logic        ack_r, re_r, we_r, ac_r, irq_r;
    logic [31:0] readdata_r, snapshot_s;
    logic        request_s, first_s, accept_s, rd_op_s, wr_op_s, ctl_wr_s;
    logic        wr_full_s, wr_empty_s, rd_full_s, rd_empty_s, ri_s, wi_s;
    logic        wr_push_s, wr_pop_s, rd_push_s, rd_pop_s;
    logic        re_nxt_s, we_nxt_s, ac_nxt_s, irq_nxt_s;
    logic [7:0]  rd_head_s;
    logic        unused_s;

    assign request_s      = av_chipselect & (~av_read_n | ~av_write_n);
    assign first_s        = request_s & ~ack_r;
    assign accept_s       = request_s & ack_r;
    assign rd_op_s        = ~av_read_n;
    assign wr_op_s        = ~av_write_n & av_read_n;
    assign av_waitrequest = first_s;

    assign wr_full_s  = (wr_count_r == WR_DEPTH_C);
    assign wr_empty_s = (wr_count_r == {WC{1'b0}});
    assign rd_full_s  = (rd_count_r == RD_DEPTH_C);
    assign rd_empty_s = (rd_count_r == {RC{1'b0}});
    assign wspace_s   = WR_DEPTH_C - wr_count_r;
    assign ri_s       = (rd_count_r >= RD_THRESH_C);
    assign wi_s       = (wspace_s >= WR_THRESH_C);
    assign rd_head_s  = rd_empty_s ? 8'h00 : rd_mem_r[rd_rptr_r];

    assign tx_data  = wr_mem_r[wr_rptr_r];
    assign tx_valid = ~wr_empty_s;
    assign rx_ready = ~rd_full_s & ~reset;

    // A write arriving on a full FIFO is dropped even if the consumer pops this cycle.
    assign wr_push_s = accept_s & wr_op_s & ~av_address & ~wr_full_s;
    assign wr_pop_s  = tx_valid & tx_ready;
    assign rd_push_s = rx_valid & rx_ready;
    // The pop decision follows the RVALID bit captured in the first request cycle.
    assign rd_pop_s  = accept_s & rd_op_s & ~av_address & readdata_r[15];
    assign ctl_wr_s  = accept_s & wr_op_s & av_address;

    assign av_readdata = readdata_r;
    assign irq         = irq_r;
    assign unused_s    = ^{av_writedata[31:11], av_writedata[9:8]};

    // Register snapshot for a read, taken in the first request cycle.
    always_comb begin
        snapshot_s = 32'h0000_0000;
        if (av_address) begin
            snapshot_s = {16'(wspace_s), 5'd0, ac_r, wi_s, ri_s, 6'd0, we_r, re_r};
        end else begin
            snapshot_s = {16'(rd_count_r), ~rd_empty_s, 7'd0, rd_head_s};
        end
    end

    // Post-update occupancy, control bits and interrupt level.
    always_comb begin
        wr_count_nxt_s = wr_count_r;
        rd_count_nxt_s = rd_count_r;
        re_nxt_s       = re_r;
        we_nxt_s       = we_r;
        ac_nxt_s       = ac_r;
        case ({wr_push_s, wr_pop_s})
            2'b10:   wr_count_nxt_s = wr_count_r + WC'(1);
            2'b01:   wr_count_nxt_s = wr_count_r - WC'(1);
            default: wr_count_nxt_s = wr_count_r;
        endcase
        case ({rd_push_s, rd_pop_s})
            2'b10:   rd_count_nxt_s = rd_count_r + RC'(1);
            2'b01:   rd_count_nxt_s = rd_count_r - RC'(1);
            default: rd_count_nxt_s = rd_count_r;
        endcase
        if (ctl_wr_s) begin
            re_nxt_s = av_writedata[0];
            we_nxt_s = av_writedata[1];
        end else begin
            re_nxt_s = re_r;
            we_nxt_s = we_r;
        end
        if (wr_pop_s) begin
            ac_nxt_s = 1'b1;
        end else if (ctl_wr_s && av_writedata[10]) begin
            ac_nxt_s = 1'b0;
        end else begin
            ac_nxt_s = ac_r;
        end
        irq_nxt_s = (re_nxt_s & (rd_count_nxt_s >= RD_THRESH_C)) |
                    (we_nxt_s & ((WR_DEPTH_C - wr_count_nxt_s) >= WR_THRESH_C));
    end

    // Bus handshake, control state, FIFO pointers and counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_r      <= 1'b0;
            readdata_r <= 32'h0000_0000;
            re_r       <= 1'b0;
            we_r       <= 1'b0;
            ac_r       <= 1'b0;
            irq_r      <= 1'b0;
            wr_wptr_r  <= {WA{1'b0}};
            wr_rptr_r  <= {WA{1'b0}};
            wr_count_r <= {WC{1'b0}};
            rd_wptr_r  <= {RA{1'b0}};
            rd_rptr_r  <= {RA{1'b0}};
            rd_count_r <= {RC{1'b0}};
        end else begin
            ack_r <= first_s;
            if (first_s && rd_op_s) begin
                readdata_r <= snapshot_s;
            end
            re_r       <= re_nxt_s;
            we_r       <= we_nxt_s;
            ac_r       <= ac_nxt_s;
            irq_r      <= irq_nxt_s;
            wr_count_r <= wr_count_nxt_s;
            rd_count_r <= rd_count_nxt_s;
            if (wr_push_s) wr_wptr_r <= wr_wptr_r + WA'(1);
            if (wr_pop_s)  wr_rptr_r <= wr_rptr_r + WA'(1);
            if (rd_push_s) rd_wptr_r <= rd_wptr_r + RA'(1);
            if (rd_pop_s)  rd_rptr_r <= rd_rptr_r + RA'(1);
        end
    end

    // Byte storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (wr_push_s) wr_mem_r[wr_wptr_r] <= av_writedata[7:0];
        if (rd_push_s) rd_mem_r[rd_wptr_r] <= rx_data;
    end

endmodule
